btn_conditioner: RTL and testbench

- Input stage between the raw board buttons and the game logic (hero state generator and main state machine).
- Synchronises and debounces the 4 direction buttons, then produces clean levels, one-cycle press pulses, and a latched last-pressed direction.
- Also produces a "step" pulse stream with auto-repeat while exactly one button is held, so hero movement has a defined cadence.
- Replaces the ad-hoc parity-based "pressing" signal.

---
 rtl/btn_conditioner_pkg.sv | 30 +++
 rtl/btn_debounce_bit.sv | 52 +++++
 rtl/btn_conditioner.sv | 148 ++++++++++++++
 tb/tb_btn_conditioner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button conditioner.
// - Direction codes driven on dir.
// - Bit positions of each button within the 4-bit button vectors.
// - State type of the auto-repeat FSM.
// - Helper that detects exactly one active button.
package btn_conditioner_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // True when exactly one bit of v is set. Clearing the lowest set bit
    // leaves zero only for a single-bit value.
    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// Synchroniser plus debouncer for one raw button.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   raw   - raw, asynchronous button level
//   clean - debounced level; changes only after the synchronised input
//           has disagreed with it for DEBOUNCE_CYCLES consecutive cycles
module btn_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             clean_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            clean_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != clean_reg) begin
                // Counter restarts after every accepted change, so it only
                // ever measures one uninterrupted run of disagreement.
                if (cnt_reg == CNT_LAST) begin
                    clean_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign clean = clean_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Button input stage for the game logic: debounced levels, press pulses,
// last-pressed direction and a movement step stream with auto-repeat.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-high reset
//   btn         - raw buttons [0]=up [1]=down [2]=left [3]=right
//   btn_clean   - debounced button levels
//   press_pulse - one-cycle pulse per button, cycle after its clean rise
//   pressing    - exactly one clean button is held
//   dir         - last pressed direction (up > down > left > right on ties)
//   dir_valid   - a press has been accepted since reset
//   step        - movement pulse on press and on auto-repeat
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic [3:0] btn_clean,
    output logic [3:0] press_pulse,
    output logic       pressing,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       step
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [3:0]       clean;
    logic [3:0]       btn_clean_d_reg;
    logic [3:0]       press_pulse_reg;
    logic [3:0]       rise;
    logic [1:0]       dir_reg;
    logic [1:0]       dir_next;
    logic             dir_valid_reg;
    logic             dir_valid_next;
    rep_state_t       state_reg;
    rep_state_t       state_next;
    logic [CNT_W-1:0] rep_cnt_reg;
    logic [CNT_W-1:0] rep_cnt_next;
    logic             step_next;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
            btn_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .raw  (btn[gi]),
                .clean(clean[gi])
            );
        end
    endgenerate

    assign rise     = clean & ~btn_clean_d_reg;
    assign pressing = one_hot4(clean);

    // dir is updated from the same rise term that loads press_pulse, so
    // both change on the same edge.
    always_comb begin
        dir_next       = dir_reg;
        dir_valid_next = dir_valid_reg;
        if (rise != 4'd0) begin
            dir_valid_next = 1'b1;
            if (rise[BTN_UP])
                dir_next = DIR_UP;
            else if (rise[BTN_DOWN])
                dir_next = DIR_DOWN;
            else if (rise[BTN_LEFT])
                dir_next = DIR_LEFT;
            else
                dir_next = DIR_RIGHT;
        end
    end

    // A new press always wins: it steps immediately and restarts the
    // initial delay. Losing the single-button condition (release or a
    // second button) drops back to IDLE without a step.
    always_comb begin
        state_next   = state_reg;
        rep_cnt_next = rep_cnt_reg;
        step_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                rep_cnt_next = '0;
                if (press_pulse_reg != 4'd0) begin
                    step_next  = 1'b1;
                    state_next = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (press_pulse_reg != 4'd0) begin
                    step_next    = 1'b1;
                    rep_cnt_next = '0;
                    state_next   = DELAY;
                end else if (!pressing) begin
                    rep_cnt_next = '0;
                    state_next   = IDLE;
                end else if ((state_reg == DELAY  && rep_cnt_reg == DELAY_LAST) ||
                             (state_reg == REPEAT && rep_cnt_reg == PERIOD_LAST)) begin
                    step_next    = 1'b1;
                    rep_cnt_next = '0;
                    state_next   = REPEAT;
                end else begin
                    rep_cnt_next = rep_cnt_reg + CNT_ONE;
                end
            end
            default: begin
                rep_cnt_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_clean_d_reg <= 4'd0;
            press_pulse_reg <= 4'd0;
            dir_reg         <= DIR_UP;
            dir_valid_reg   <= 1'b0;
            state_reg       <= IDLE;
            rep_cnt_reg     <= '0;
        end else begin
            btn_clean_d_reg <= clean;
            press_pulse_reg <= rise;
            dir_reg         <= dir_next;
            dir_valid_reg   <= dir_valid_next;
            state_reg       <= state_next;
            rep_cnt_reg     <= rep_cnt_next;
        end
    end

    assign btn_clean   = clean;
    assign press_pulse = press_pulse_reg;
    assign dir         = dir_reg;
    assign dir_valid   = dir_valid_reg;
    assign step        = step_next;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'd0;
    logic [3:0] btn_clean;
    logic [3:0] press_pulse;
    logic       pressing;
    logic [1:0] dir;
    logic       dir_valid;
    logic       step;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .btn_clean  (btn_clean),
        .press_pulse(press_pulse),
        .pressing   (pressing),
        .dir        (dir),
        .dir_valid  (dir_valid),
        .step       (step)
    );

    // Reference model: edge-indexed histories since reset. A clean bit flips
    // when the last DB synchronised samples (raw delayed by two edges) all
    // disagree with it. Steps are derived from the distance to the last press.
    logic [3:0] raw_hist[$];
    logic [3:0] clean_hist[$];
    logic [3:0] m_clean = 4'd0;
    logic [3:0] m_pulse = 4'd0;
    logic [1:0] m_dir = 2'd0;
    logic       m_valid = 1'b0;
    logic       m_pressing = 1'b0;
    logic       m_step = 1'b0;
    logic       m_alive = 1'b0;
    int         m_anchor = 0;
    logic [3:0] smp_btn;

    function automatic logic [3:0] raw_at(input int j);
        if (j < 1 || j > raw_hist.size()) return 4'd0;
        return raw_hist[j-1];
    endfunction

    function automatic logic [3:0] clean_at(input int j);
        if (j < 1 || j > clean_hist.size()) return 4'd0;
        return clean_hist[j-1];
    endfunction

    task automatic model_reset();
        raw_hist.delete();
        clean_hist.delete();
        m_clean = 4'd0; m_pulse = 4'd0; m_dir = 2'd0; m_valid = 1'b0;
        m_pressing = 1'b0; m_step = 1'b0; m_alive = 1'b0; m_anchor = 0;
    endtask

    task automatic model_edge(input logic [3:0] b);
        int k;
        int d;
        logic [3:0] s;
        logic [3:0] nc;
        bit differs;
        raw_hist.push_back(b);
        k  = raw_hist.size();
        nc = m_clean;
        for (int n = 0; n < 4; n++) begin
            differs = 1'b1;
            for (int j = k - DB + 1; j <= k; j++) begin
                s = raw_at(j - 2);
                if (s[n] == m_clean[n]) differs = 1'b0;
            end
            if (differs) nc[n] = ~m_clean[n];
        end
        m_clean = nc;
        clean_hist.push_back(nc);
        m_pulse    = clean_at(k - 1) & ~clean_at(k - 2);
        m_pressing = ($countones(m_clean) == 1);
        if (m_pulse != 4'd0) begin
            m_valid = 1'b1;
            for (int n = 3; n >= 0; n--) if (m_pulse[n]) m_dir = 2'(n);
        end
        if (m_pulse != 4'd0) begin
            m_step = 1'b1; m_anchor = k; m_alive = 1'b1;
        end else if (m_alive && m_pressing) begin
            d = k - m_anchor;
            m_step = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
        end else begin
            m_alive = 1'b0; m_step = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            smp_btn = btn;
            model_edge(smp_btn);
            #1;
            tests++;
            if ({btn_clean, press_pulse, pressing, dir, dir_valid, step} !==
                {m_clean, m_pulse, m_pressing, m_dir, m_valid, m_step}) begin
                fails++;
                $display("FAIL model_cycle t=%0t: got clean=%b pulse=%b pressing=%b dir=%b valid=%b step=%b, expected clean=%b pulse=%b pressing=%b dir=%b valid=%b step=%b",
                         $time, btn_clean, press_pulse, pressing, dir, dir_valid, step,
                         m_clean, m_pulse, m_pressing, m_dir, m_valid, m_step);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives pa for edges 1..hold (plus pb from edge tstart), then zero.
    task automatic run(input logic [3:0] pa, input logic [3:0] pb, input int tstart,
                       input int hold, input int total,
                       output int nsteps, output int first, output int second,
                       output logic [3:0] pp_or, output logic press_at_hold);
        nsteps = 0; first = -1; second = -1; pp_or = 4'd0; press_at_hold = 1'b0;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            if (i <= hold) btn = pa | ((tstart > 0 && i >= tstart) ? pb : 4'd0);
            else           btn = 4'd0;
            @(posedge clk); #1;
            pp_or |= press_pulse;
            if (step) begin
                nsteps++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (i == hold) press_at_hold = pressing;
        end
    endtask

    int         ns, f1, f2;
    logic [3:0] ppo;
    logic       pah;
    logic [3:0] pat;
    int         r, len;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {24'd0, btn_clean, press_pulse}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        run(4'b0100, 4'd0, 0, 3, 15, ns, f1, f2, ppo, pah);
        chk("glitch_steps", ns, 0);
        chk("glitch_pulse", ppo, 4'b0000);
        chk("glitch_valid", dir_valid, 0);

        run(4'b0100, 4'd0, 0, 30, 45, ns, f1, f2, ppo, pah);
        chk("hold_steps", ns, 8);
        chk("hold_first", f1, 7);
        chk("hold_second", f2, 15);
        chk("hold_dir", dir, 2'b10);
        chk("hold_valid", dir_valid, 1);

        run(4'b1010, 4'd0, 0, 20, 40, ns, f1, f2, ppo, pah);
        chk("simul_steps", ns, 1);
        chk("simul_pulse", ppo, 4'b1010);
        chk("simul_dir", dir, 2'b01);
        chk("simul_pressing", pah, 0);

        run(4'b0001, 4'b1000, 20, 40, 60, ns, f1, f2, ppo, pah);
        chk("second_steps", ns, 6);
        chk("second_pulse", ppo, 4'b1001);
        chk("second_dir", dir, 2'b11);
        chk("second_pressing", pah, 0);

        run(4'b0010, 4'd0, 0, 12, 25, ns, f1, f2, ppo, pah);
        chk("repress_steps", ns, 2);
        chk("repress_first", f1, 7);
        chk("repress_second", f2, 15);
        chk("repress_dir", dir, 2'b01);
        chk("repress_valid", dir_valid, 1);

        // Reset while a button is held and the repeat FSM is running.
        @(negedge clk); btn = 4'b0001;
        repeat (20) @(negedge clk);
        rst = 1'b1; #1;
        chk("midreset_clean", btn_clean, 4'd0);
        chk("midreset_pulse", press_pulse, 4'd0);
        chk("midreset_misc", {pressing, dir, dir_valid, step}, 5'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 5) chk("rel_clean_e5", btn_clean, 4'b0000);
            if (i == 6) chk("rel_clean_e6", btn_clean, 4'b0001);
            if (i == 7) begin
                chk("rel_pulse_e7", press_pulse, 4'b0001);
                chk("rel_step_e7", step, 1);
                chk("rel_valid_e7", dir_valid, 1);
            end
            if (i == 8) chk("rel_step_e8", step, 0);
        end
        @(negedge clk); btn = 4'd0;
        repeat (12) @(negedge clk);

        // Random segments, mostly single buttons so repeats get exercised.
        for (int s = 0; s < 120; s++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      pat = 4'b0001 << $urandom_range(0, 3);
            else if (r < 8) pat = 4'($urandom_range(0, 15));
            else            pat = 4'd0;
            len = $urandom_range(1, 30);
            repeat (len) begin
                @(negedge clk);
                btn = pat;
            end
            if (s == 60) begin
                @(negedge clk); rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
        end
        @(negedge clk); btn = 4'd0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
